// File: rtl/expr_pipe_eval_if.sv
// Handshake bundle for expr_pipe_eval: operand beat in, result beat out.
// The slave modport is the evaluator; the master modport is the producer/consumer side.
interface expr_pipe_eval_if #(
    parameter int W = 8
);
    logic         in_valid;
    logic         in_ready;
    logic [2:0]   in_op;
    logic [W-1:0] in_a;
    logic [W-1:0] in_b;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_res;
    logic [2:0]   out_flags;

    modport master (
        output in_valid, in_op, in_a, in_b, out_ready,
        input  in_ready, out_valid, out_res, out_flags
    );

    modport slave (
        input  in_valid, in_op, in_a, in_b, out_ready,
        output in_ready, out_valid, out_res, out_flags
    );
endinterface

// File: rtl/expr_pipe_eval.sv
// expr_pipe_eval: pipelined 8-op ALU evaluator with valid/ready flow control.
// The result and flags {ovf, neg, zero} are computed in stage 0; the remaining
// PIPE-1 stages only carry the registered result toward the output.
// Optional build macro EXPR_PIPE_EVAL_SAT_EN: add/sub saturate to the signed
// range on overflow instead of wrapping.
module expr_pipe_eval #(
    parameter int W    = 8,
    parameter int PIPE = 2
) (
    input  logic             clk,
    input  logic             reset_n,
    expr_pipe_eval_if.slave  bus
);
    localparam logic [W-1:0] SMAX = {1'b0, {(W-1){1'b1}}};
    localparam logic [W-1:0] SMIN = {1'b1, {(W-1){1'b0}}};

    logic [PIPE-1:0] vld_q;
    logic [W-1:0]    res_q [PIPE];
    logic [2:0]      flg_q [PIPE];

    logic [W-1:0]    res_d;
    logic [2:0]      flg_d;
    logic [PIPE-1:0] ld;

    // Stage-0 datapath: operation result, overflow and derived flags.
    always_comb begin
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] sum;
        logic [W-1:0] dif;
        logic         ovf;
        a     = bus.in_a;
        b     = bus.in_b;
        sum   = a + b;
        dif   = a - b;
        ovf   = 1'b0;
        res_d = '0;
        case (bus.in_op)
            3'd0: begin
                res_d = sum;
                ovf   = (a[W-1] == b[W-1]) && (sum[W-1] != a[W-1]);
            end
            3'd1: begin
                res_d = dif;
                ovf   = (a[W-1] != b[W-1]) && (dif[W-1] != a[W-1]);
            end
            3'd2: res_d = ~(a ^ b);
            3'd3: begin
                if (32'(b) >= 32'(W)) res_d = {W{a[W-1]}};
                else                  res_d = $signed(a) >>> b;
            end
            3'd4: begin
                if (32'(b) >= 32'(W)) res_d = '0;
                else                  res_d = a << b;
            end
            3'd5: res_d[0] = a < b;
            3'd6: res_d[0] = $signed(a) < $signed(b);
            default: res_d[0] = ^{a, b};
        endcase
`ifdef EXPR_PIPE_EVAL_SAT_EN
        // On add/sub overflow the true result lies beyond the limit on A's side.
        if (ovf) res_d = a[W-1] ? SMIN : SMAX;
`else
`endif
        flg_d = {ovf, res_d[W-1], (res_d == '0)};
    end

    // Load enables: a stage may take new data when it, or any stage after it,
    // has a free slot, or the output is being consumed (collapses bubbles).
    always_comb begin
        logic room;
        room = bus.out_ready;
        ld   = '0;
        for (int unsigned k = 0; k < PIPE; k++) begin
            room             = room || !vld_q[PIPE-1-k];
            ld[PIPE-1-k]     = room;
        end
    end

    // Pipeline registers: stage 0 captures computed beats, later stages shift.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            vld_q <= '0;
            for (int unsigned i = 0; i < PIPE; i++) begin
                res_q[i] <= '0;
                flg_q[i] <= '0;
            end
        end else begin
            if (ld[0]) begin
                vld_q[0] <= bus.in_valid;
                if (bus.in_valid) begin
                    res_q[0] <= res_d;
                    flg_q[0] <= flg_d;
                end
            end
            for (int unsigned i = 1; i < PIPE; i++) begin
                if (ld[i]) begin
                    vld_q[i] <= vld_q[i-1];
                    if (vld_q[i-1]) begin
                        res_q[i] <= res_q[i-1];
                        flg_q[i] <= flg_q[i-1];
                    end
                end
            end
        end
    end

    assign bus.in_ready  = reset_n & ld[0];
    assign bus.out_valid = vld_q[PIPE-1];
    assign bus.out_res   = res_q[PIPE-1];
    assign bus.out_flags = flg_q[PIPE-1];
endmodule
